// File: rtl/store_buffer_pkg.sv
// Shared widths and the buffered-store record for the posted-write store buffer.
package store_buffer_pkg;
   localparam int SB_DEPTH  = 4;
   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;
   localparam int SB_CNT_W  = 16;
   localparam int BE_W      = SB_DATA_W / 8;
   localparam int PTR_W     = $clog2(SB_DEPTH);

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
      logic [BE_W-1:0]      be;
   } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: youngest valid entry whose word address matches the load wins.
module sb_fwd_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
)(
   input  sb_entry_t [DEPTH-1:0]     entries,
   input  logic      [DEPTH-1:0]     valid,
   input  logic      [PTR_W-1:0]     tail,
   input  logic      [SB_ADDR_W-1:0] LoadAddr,
   output logic                      FwdHit,
   output logic      [SB_DATA_W-1:0] FwdData,
   output logic                      FwdConflict
);
   localparam logic [SB_ADDR_W-1:0] WORD_MASK = ~SB_ADDR_W'(3);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      FwdHit      = 1'b0;
      FwdData     = '0;
      FwdConflict = 1'b0;
      found       = 1'b0;
      idx         = '0;
      // walk from the slot just behind tail (youngest) back toward head
      for (int k = 0; k < DEPTH; k++) begin
         idx = tail - PTR_W'(k + 1);
         if (!found && valid[idx] &&
             (((entries[idx].addr ^ LoadAddr) & WORD_MASK) == '0)) begin
            found = 1'b1;
            if (&entries[idx].be) begin
               FwdHit  = 1'b1;
               FwdData = entries[idx].data;
            end else begin
               FwdConflict = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store port and a valid/ready data memory,
// with load snooping so the core observes its own undrained stores.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W,
   parameter int CNT_W  = SB_CNT_W
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                MemWrite,
   input  logic [ADDR_W-1:0]   ALUResult,
   input  logic [DATA_W-1:0]   WriteData,
   input  logic [DATA_W/8-1:0] ByteEn,
   input  logic [ADDR_W-1:0]   LoadAddr,
   output logic                StoreStall,
   output logic                FwdHit,
   output logic [DATA_W-1:0]   FwdData,
   output logic                FwdConflict,
   output logic                Drained,
   output logic                mem_valid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   output logic [CNT_W-1:0]    RetiredCnt
);
   sb_entry_t [DEPTH-1:0] ent_q;
   logic [PTR_W-1:0]      head, tail;
   logic [PTR_W:0]        count;
   logic [DEPTH-1:0]      valid;
   logic                  push, pop;

   // full/empty come from registered count only, so mem_ready never reaches StoreStall
   assign StoreStall = (count == (PTR_W+1)'(DEPTH));
   assign Drained    = (count == '0);
   assign mem_valid  = !Drained;
   assign push       = MemWrite && !StoreStall;
   assign pop        = mem_valid && mem_ready;

   assign mem_addr   = ent_q[head].addr;
   assign mem_wdata  = ent_q[head].data;
   assign mem_be     = ent_q[head].be;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_q      <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         RetiredCnt <= '0;
      end else begin
         if (push) begin
            ent_q[tail] <= '{addr: ALUResult, data: WriteData, be: ByteEn};
            tail        <= tail + 1'b1;
         end
         if (pop) begin
            head       <= head + 1'b1;
            RetiredCnt <= RetiredCnt + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // slot i is live when its distance from head is below the occupancy
   for (genvar i = 0; i < DEPTH; i++) begin : g_valid
      logic [PTR_W-1:0] off;
      assign off      = PTR_W'(i) - head;
      assign valid[i] = ({1'b0, off} < count);
   end

   sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
      .entries     (ent_q),
      .valid       (valid),
      .tail        (tail),
      .LoadAddr    (LoadAddr),
      .FwdHit      (FwdHit),
      .FwdData     (FwdData),
      .FwdConflict (FwdConflict)
   );
endmodule
